reg_channel_mux: RTL and testbench

Parametrised, registered N-channel multiplexer with valid/ready handshaking. It is the next generation of the 1-bit two-to-one mux. It selects one of NUM_CH input channels of WIDTH bits, either from an explicit select (fixed mode) or by round-robin arbitration. The chosen word is held in an output register until the consumer accepts it. It is used in the datapath wherever several producers (register-file read ports, ALU/immediate/memory results) share one destination that can stall.

---
 rtl/reg_channel_mux.sv | 144 ++++++++++++++
 tb/tb_reg_channel_mux.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/reg_channel_mux.sv
// Registered N-channel multiplexer with valid/ready handshake; fixed-select or
// round-robin source choice, one output register with full throughput.
module reg_channel_mux #(
   parameter int WIDTH  = 32,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_valid,
   output logic [NUM_CH-1:0]       in_ready,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    mode,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SEL_W-1:0]        out_ch
);

   logic [WIDTH-1:0]  out_data_r;
   logic              out_valid_r;
   logic [SEL_W-1:0]  out_ch_r;
   logic [SEL_W-1:0]  last_r;

   logic              fix_valid_s;
   logic              hi_found_s;
   logic              lo_found_s;
   logic [SEL_W-1:0]  hi_idx_s;
   logic [SEL_W-1:0]  lo_idx_s;
   logic              grant_valid_s;
   logic [SEL_W-1:0]  grant_s;
   logic [WIDTH-1:0]  grant_data_s;
   logic              can_load_s;
   logic              load_s;
   logic [NUM_CH-1:0] in_ready_s;

   // Fixed-mode grant: an out-of-range sel never matches any channel
   always_comb begin
      fix_valid_s = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         fix_valid_s = fix_valid_s | ((sel == SEL_W'(i)) & in_valid[i]);
      end
   end

   // Round-robin search split into channels above last_r and those at or below it;
   // the descending scan leaves the lowest requester of each half in its index
   always_comb begin
      hi_found_s = 1'b0;
      lo_found_s = 1'b0;
      hi_idx_s   = '0;
      lo_idx_s   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         hi_idx_s   = (in_valid[i] && (SEL_W'(i) > last_r))  ? SEL_W'(i) : hi_idx_s;
         lo_idx_s   = (in_valid[i] && (SEL_W'(i) <= last_r)) ? SEL_W'(i) : lo_idx_s;
         hi_found_s = hi_found_s | (in_valid[i] & (SEL_W'(i) > last_r));
         lo_found_s = lo_found_s | (in_valid[i] & (SEL_W'(i) <= last_r));
      end
   end

   // Final grant, handshake qualification and data selection
   always_comb begin
      if (mode) begin
         grant_valid_s = hi_found_s | lo_found_s;
         grant_s       = hi_found_s ? hi_idx_s : lo_idx_s;
      end else begin
         grant_valid_s = fix_valid_s;
         grant_s       = sel;
      end
      can_load_s   = ~out_valid_r | out_ready;
      load_s       = can_load_s & grant_valid_s & rst_n;
      in_ready_s   = '0;
      grant_data_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         in_ready_s[i] = load_s & (grant_s == SEL_W'(i));
         grant_data_s  = (grant_s == SEL_W'(i)) ? in_data[i*WIDTH +: WIDTH] : grant_data_s;
      end
   end

   // Output register and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_r  <= '0;
         out_valid_r <= 1'b0;
         out_ch_r    <= '0;
         last_r      <= SEL_W'(NUM_CH - 1);
      end else if (load_s) begin
         out_data_r  <= grant_data_s;
         out_valid_r <= 1'b1;
         out_ch_r    <= grant_s;
         last_r      <= grant_s;
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_data  = out_data_r;
   assign out_valid = out_valid_r;
   assign out_ch    = out_ch_r;

   reg_channel_mux_chk #(
      .WIDTH  (WIDTH),
      .NUM_CH (NUM_CH),
      .SEL_W  (SEL_W)
   ) u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_ready  (in_ready_s),
      .out_data  (out_data_r),
      .out_valid (out_valid_r),
      .out_ready (out_ready),
      .out_ch    (out_ch_r)
   );

endmodule

// Protocol properties of the mux: single grant, frozen output while stalled.
module reg_channel_mux_chk #(
   parameter int WIDTH  = 32,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = 2
) (
   input logic              clk,
   input logic              rst_n,
   input logic [NUM_CH-1:0] in_ready,
   input logic [WIDTH-1:0]  out_data,
   input logic              out_valid,
   input logic              out_ready,
   input logic [SEL_W-1:0]  out_ch
);

   a_one_grant: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(in_ready));

   a_stall_no_ready: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |-> (in_ready == '0));

   a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_ch)));

endmodule

// File: tb/tb_reg_channel_mux.sv
// Scoreboard bench for reg_channel_mux with WIDTH=8, NUM_CH=4.
module tb_reg_channel_mux;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N*W-1:0] in_data;
   logic [N-1:0]  in_valid;
   logic [N-1:0]  in_ready;
   logic [SW-1:0] sel;
   logic          mode;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] out_ch;

   int total = 0;
   int bad   = 0;

   logic [SW+W-1:0] sb[$];
   logic [SW+W-1:0] held;

   always #5 clk = ~clk;

   reg_channel_mux #(.WIDTH(W), .NUM_CH(N), .SEL_W(SW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .mode      (mode),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock: check in_ready, queue the expected word, then check the output register
   task automatic run_cycle(input string tag, input logic [N-1:0] exp_rdy, input logic exp_ov);
      int ch;
      #1;
      check({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
      if (exp_rdy != '0) begin
         ch = 0;
         for (int i = 0; i < N; i++) begin
            if (exp_rdy[i]) ch = i;
         end
         sb.push_back({SW'(ch), in_data[ch*W +: W]});
      end
      @(posedge clk);
      #1;
      check({tag, " out_valid"}, 32'(out_valid), 32'(exp_ov));
      if (sb.size() != 0) held = sb.pop_front();
      check({tag, " out_ch"}, 32'(out_ch), 32'(held[W +: SW]));
      check({tag, " out_data"}, 32'(out_data), 32'(held[W-1:0]));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = 4'b1111;
      mode      = 1'b1;
      sel       = 2'd0;
      out_ready = 1'b0;
      held      = '0;
      #2;
      check("rst in_ready", 32'(in_ready), 32'h0);
      check("rst out_valid", 32'(out_valid), 32'h0);
      check("rst out_data", 32'(out_data), 32'h0);
      check("rst out_ch", 32'(out_ch), 32'h0);
      in_valid = 4'b0000;
      #20;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: idle after reset
      for (int k = 0; k < 10; k++) run_cycle("t1 idle", 4'b0000, 1'b0);

      // 2: fixed mode, then a select with no valid word
      mode = 1'b0; sel = 2'd2; in_valid = 4'b0110; out_ready = 1'b1;
      in_data = 32'h0022_1100;
      run_cycle("t2 sel2", 4'b0100, 1'b1);
      sel = 2'd3;
      run_cycle("t2 sel3 none", 4'b0000, 1'b0);
      in_valid = 4'b1000; in_data = 32'h3300_0000;
      run_cycle("t2 sel3", 4'b1000, 1'b1);

      // 3: round-robin over all channels, back to back
      mode = 1'b1; in_valid = 4'b1111; in_data = 32'hA3A2_A1A0;
      run_cycle("t3 rr0", 4'b0001, 1'b1);
      run_cycle("t3 rr1", 4'b0010, 1'b1);
      run_cycle("t3 rr2", 4'b0100, 1'b1);
      run_cycle("t3 rr3", 4'b1000, 1'b1);
      run_cycle("t3 rr0b", 4'b0001, 1'b1);

      // 4: stall with inputs churning
      mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data = 32'h0000_5A00;
      run_cycle("t4 load", 4'b0010, 1'b1);
      out_ready = 1'b0; in_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         sel     = SW'(k);
         mode    = 1'(k % 2);
         in_data = $urandom;
         run_cycle("t4 stall", 4'b0000, 1'b1);
      end
      out_ready = 1'b1; mode = 1'b1; in_data = 32'hC3C2_C1C0;
      run_cycle("t4 resume", 4'b0100, 1'b1);

      // 5: alternating fairness between ch0 and ch3
      mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data = 32'h0000_00E0;
      run_cycle("t5 set last0", 4'b0001, 1'b1);
      mode = 1'b1; in_valid = 4'b1001; in_data = 32'hD3D2_D1D0;
      run_cycle("t5 rr ch3", 4'b1000, 1'b1);
      run_cycle("t5 rr ch0", 4'b0001, 1'b1);
      run_cycle("t5 rr ch3b", 4'b1000, 1'b1);

      // 6: asynchronous reset with a pending word
      mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data = 32'h0000_7700;
      run_cycle("t6 load", 4'b0010, 1'b1);
      out_ready = 1'b0; in_valid = 4'b0000;
      #2;
      rst_n = 1'b0;
      #1;
      check("t6 async out_valid", 32'(out_valid), 32'h0);
      check("t6 async out_data", 32'(out_data), 32'h0);
      check("t6 async out_ch", 32'(out_ch), 32'h0);
      check("t6 async in_ready", 32'(in_ready), 32'h0);
      sb.delete();
      held = '0;
      @(posedge clk);
      #1;
      check("t6 held out_valid", 32'(out_valid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; in_data = 32'hB3B2_B1B0;
      run_cycle("t6 rr restart", 4'b0001, 1'b1);
      run_cycle("t6 rr next", 4'b0010, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
